dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's data port. It accepts one load or store request at a time over a valid/ready handshake and waits a programmable number of cycles. It then performs the word access on an internal word array and returns a response over a second valid/ready handshake. It replaces the single-cycle data memory when the team models multi-cycle memory behind a stalling MEM stage.

---
 rtl/dmem_responder.sv | 75 +++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with valid/ready request and response handshakes
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, commit, c_write, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [IW-1:0] idx;
    assign accept = (state == IDLE) && req_valid_i;
    assign commit = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
    assign c_write = (state == IDLE) ? req_write_i : lat_write;
    assign c_addr = (state == IDLE) ? req_addr_i : lat_addr;
    assign c_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;
    assign c_err = (c_addr[1:0] != 2'b0) || (c_addr[31:2] >= 30'(DEPTH_WORDS));
    assign idx = c_addr[IW+1:2];
    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else state <= state_nx;
    end
    // next state: accept, count down to the commit, hold the response until taken
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (accept ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
                   (state == WAIT) ? (commit ? RESP : WAIT) :
                   (rsp_ready_i ? IDLE : RESP);
    end
    // request latch, wait counter, array access and registered response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
            lat_write <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                lat_write <= req_write_i;
                lat_addr <= req_addr_i;
                lat_wdata <= req_wdata_i;
                cnt <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err_o <= c_err;
                rsp_rdata_o <= (c_err || c_write) ? '0 : mem[idx];
                if (!c_err && c_write) mem[idx] <= c_wdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
module tb_dmem_responder;
    logic clk = 0;
    logic rst_n = 0;
    logic a_req_valid = 0, a_req_ready, a_req_write = 0, a_rsp_valid, a_rsp_ready = 1, a_rsp_err;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_rsp_rdata;
    logic b_req_valid = 0, b_req_ready, b_req_write = 0, b_rsp_valid, b_rsp_err;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_rdata;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_a (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_b (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b1),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
    );

    // issue one request on u_a from IDLE, wait (bounded) for the response, take it if rsp_ready is high
    task automatic req_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic e);
        a_req_valid = 1; a_req_write = w; a_req_addr = a; a_req_wdata = d;
        @(posedge clk); #1;
        a_req_valid = 0;
        lat = 0;
        while (!a_rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = a_rsp_rdata;
        e = a_rsp_err;
        if (a_rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", a_req_ready); end
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); end
        tests++; if (a_rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", a_rsp_rdata); end
        tests++; if (a_rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", a_rsp_err); end
        tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_b_rsp_valid got %b want 0", b_rsp_valid); end
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic e;
        req_a(1, 32'h10, 32'hDEADBEEF, lat, rd, e);
        tests++; if (lat !== 2) begin fails++; $display("FAIL store_latency got %0d want 2", lat); end
        tests++; if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", rd, e); end
        tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL store_back_idle got %b want 1", a_req_ready); end
        req_a(0, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL load_10 got rdata=%h err=%b want deadbeef/0", rd, e); end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic e;
        a_rsp_ready = 0;
        req_a(0, 32'h10, 32'h0, lat, rd, e);
        tests++; if (lat !== 2 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_first got lat=%0d rdata=%h want 2/deadbeef", lat, rd); end
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h10; a_req_wdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || a_req_ready !== 1'b0)
                begin fails++; $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b want 1/deadbeef/0", i, a_rsp_valid, a_rsp_rdata, a_req_ready); end
        end
        a_req_valid = 0;
        a_rsp_ready = 1;
        @(posedge clk); #1;
        tests++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", a_req_ready, a_rsp_valid); end
        req_a(0, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_no_commit got %h want deadbeef", rd); end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic e;
        req_a(1, 32'h12, 32'hAAAA5555, lat, rd, e);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_store got err=%b rdata=%h want 1/0", e, rd); end
        req_a(0, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL after_err_load got %h/%b want deadbeef/0", rd, e); end
        req_a(0, 32'h200, 32'h0, lat, rd, e);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oob_load got err=%b rdata=%h want 1/0", e, rd); end
        req_a(0, 32'h1FC, 32'h0, lat, rd, e);
        tests++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL last_word_load got err=%b rdata=%h want 0/0", e, rd); end
        req_a(1, 32'h1FC, 32'h0BADF00D, lat, rd, e);
        req_a(0, 32'h1FC, 32'h0, lat, rd, e);
        tests++; if (e !== 1'b0 || rd !== 32'h0BADF00D) begin fails++; $display("FAIL last_word_rw got err=%b rdata=%h want 0/0badf00d", e, rd); end
        req_a(1, 32'h200, 32'h77777777, lat, rd, e);
        req_a(0, 32'h0, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oob_store_wrap got %h want 0", rd); end
    endtask

    task automatic test_input_change;
        int lat; logic [31:0] rd; logic e;
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h30; a_req_wdata = 32'h11112222;
        @(posedge clk); #1;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 32'h3; a_req_wdata = 32'h99999999;
        @(posedge clk); #1;
        a_req_addr = 32'h34;
        @(posedge clk); #1;
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0)
            begin fails++; $display("FAIL latched_rsp got valid=%b err=%b rdata=%h want 1/0/0", a_rsp_valid, a_rsp_err, a_rsp_rdata); end
        @(posedge clk); #1;
        req_a(0, 32'h30, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h11112222) begin fails++; $display("FAIL latched_commit got %h want 11112222", rd); end
        req_a(0, 32'h34, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL unlatched_addr got %h want 0", rd); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic e;
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h20; a_req_wdata = 32'h12345678;
        @(posedge clk); #1;
        a_req_valid = 0;
        rst_n = 0;
        #2;
        tests++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin fails++; $display("FAIL async_reset got ready=%b valid=%b want 1/0", a_req_ready, a_rsp_valid); end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_drop%0d got valid=%b want 0", i, a_rsp_valid); end
        end
        req_a(0, 32'h20, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL dropped_store got %h want 0", rd); end
        req_a(0, 32'h10, 32'h0, lat, rd, e);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL array_cleared got %h want 0", rd); end
    endtask

    task automatic test_back_to_back;
        b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h0; b_req_wdata = 32'hA0A0A0A0;
        @(posedge clk); #1;
        tests++; if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_err !== 1'b0 || b_rsp_rdata !== 32'h0)
            begin fails++; $display("FAIL lat0_st0 got valid=%b ready=%b err=%b rdata=%h want 1/0/0/0", b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_rdata); end
        b_req_addr = 32'h4; b_req_wdata = 32'hB0B0B0B0;
        @(posedge clk); #1;
        tests++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin fails++; $display("FAIL lat0_gap got valid=%b ready=%b want 0/1", b_rsp_valid, b_req_ready); end
        @(posedge clk); #1;
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin fails++; $display("FAIL lat0_st4 got valid=%b err=%b want 1/0", b_rsp_valid, b_rsp_err); end
        b_req_write = 0; b_req_addr = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hA0A0A0A0) begin fails++; $display("FAIL lat0_ld0 got valid=%b rdata=%h want 1/a0a0a0a0", b_rsp_valid, b_rsp_rdata); end
        b_req_addr = 32'h4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hB0B0B0B0) begin fails++; $display("FAIL lat0_ld4 got valid=%b rdata=%h want 1/b0b0b0b0", b_rsp_valid, b_rsp_rdata); end
        b_req_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #12 rst_n = 1;
        @(posedge clk); #1;
        test_reset;
        test_store_load;
        test_backpressure;
        test_errors;
        test_input_change;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
